// File: rtl/fp32_result_collector.sv
// FWFT result FIFO behind the FP32 adder: classifies each result and keeps sticky flags.
// Optional drop counter enabled by defining FP32_COLLECTOR_DROP_CNT_EN.
module fp32_result_collector #(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   i_res,
  input  logic          i_res_vld,
  input  logic          i_ovf,
  output logic [31:0]   o_data,
  output logic [3:0]    o_flags,
  output logic          o_vld,
  input  logic          i_rdy,
  output logic [AW:0]   o_count,
  output logic          o_full,
  output logic          o_empty,
  output logic [3:0]    o_sticky,
  input  logic          i_clr_sticky,
  output logic          o_drop,
  output logic [15:0]   o_drop_cnt
);

  localparam int unsigned CW = AW + 1;

  logic [31:0]   mem_data  [DEPTH];
  logic [3:0]    mem_flags [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [AW:0]   count_nxt;
  logic [31:0]   head_data_nxt;
  logic [3:0]    head_flags_nxt;
  logic [3:0]    flags_c;
  logic [3:0]    sticky_nxt;
  logic          drop_nxt;
  logic          push, pop, drop_ev;
  logic [7:0]    res_exp;
  logic [22:0]   res_mant;

  // Result classification {ovf, nan, inf, zero}; sign is ignored
  always_comb begin
    res_exp  = i_res[30:23];
    res_mant = i_res[22:0];
    flags_c  = {i_ovf,
                (res_exp == 8'hFF) && (res_mant != 23'd0),
                (res_exp == 8'hFF) && (res_mant == 23'd0),
                (res_exp == 8'h00) && (res_mant == 23'd0)};
  end

  // Next-state: pointers, occupancy, head register and sticky status
  always_comb begin
    pop            = o_vld & i_rdy;
    push           = i_res_vld & (~o_full | pop);
    drop_ev        = i_res_vld & o_full & ~pop;
    wr_ptr_nxt     = push ? wr_ptr + AW'(1) : wr_ptr;
    rd_ptr_nxt     = pop  ? rd_ptr + AW'(1) : rd_ptr;
    count_nxt      = o_count;
    head_data_nxt  = o_data;
    head_flags_nxt = o_flags;
    case ({push, pop})
      2'b10:   count_nxt = o_count + CW'(1);
      2'b01:   count_nxt = o_count - CW'(1);
      default: count_nxt = o_count;
    endcase
    // A write landing on the next head slot must be forwarded into the head register
    if (push && (wr_ptr == rd_ptr_nxt)) begin
      head_data_nxt  = i_res;
      head_flags_nxt = flags_c;
    end else if (count_nxt != CW'(0)) begin
      head_data_nxt  = mem_data[rd_ptr_nxt];
      head_flags_nxt = mem_flags[rd_ptr_nxt];
    end
    sticky_nxt = (i_clr_sticky ? 4'b0000 : o_sticky) | (push ? flags_c : 4'b0000);
    drop_nxt   = (i_clr_sticky ? 1'b0 : o_drop) | drop_ev;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr]  <= i_res;
      mem_flags[wr_ptr] <= flags_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      o_count  <= '0;
      o_vld    <= 1'b0;
      o_full   <= 1'b0;
      o_empty  <= 1'b1;
      o_data   <= '0;
      o_flags  <= '0;
      o_sticky <= '0;
      o_drop   <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      o_count  <= count_nxt;
      o_vld    <= (count_nxt != CW'(0));
      o_full   <= (count_nxt == CW'(DEPTH));
      o_empty  <= (count_nxt == CW'(0));
      o_data   <= head_data_nxt;
      o_flags  <= head_flags_nxt;
      o_sticky <= sticky_nxt;
      o_drop   <= drop_nxt;
    end
  end

`ifdef FP32_COLLECTOR_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  // Saturating count of lost results; only reset clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else if (drop_ev && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign o_drop_cnt = drop_cnt_q;
`else
  assign o_drop_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_fp32_result_collector.sv
// Directed self-checking bench for fp32_result_collector (DEPTH = 8).
module tb_fp32_result_collector;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = $clog2(DEPTH);
`ifdef FP32_COLLECTOR_DROP_CNT_EN
  localparam logic [15:0] EXP_DROPS = 16'd2;
`else
  localparam logic [15:0] EXP_DROPS = 16'd0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   i_res;
  logic          i_res_vld;
  logic          i_ovf;
  logic [31:0]   o_data;
  logic [3:0]    o_flags;
  logic          o_vld;
  logic          i_rdy;
  logic [AW:0]   o_count;
  logic          o_full;
  logic          o_empty;
  logic [3:0]    o_sticky;
  logic          i_clr_sticky;
  logic          o_drop;
  logic [15:0]   o_drop_cnt;

  int errors = 0;
  int checks = 0;

  fp32_result_collector #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .i_res(i_res), .i_res_vld(i_res_vld), .i_ovf(i_ovf),
    .o_data(o_data), .o_flags(o_flags), .o_vld(o_vld), .i_rdy(i_rdy),
    .o_count(o_count), .o_full(o_full), .o_empty(o_empty), .o_sticky(o_sticky),
    .i_clr_sticky(i_clr_sticky), .o_drop(o_drop), .o_drop_cnt(o_drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_res = 32'h0; i_res_vld = 1'b0; i_ovf = 1'b0; i_rdy = 1'b0; i_clr_sticky = 1'b0;
    tick(); tick();
    rst = 1'b0;
    checks++; if (o_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b expected 0", o_vld); end
    checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", o_empty); end
    checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", o_full); end
    checks++; if (o_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", o_count); end
    checks++; if (o_sticky !== 4'b0000) begin errors++; $display("FAIL reset_sticky: got %b expected 0000", o_sticky); end
    checks++; if (o_drop !== 1'b0) begin errors++; $display("FAIL reset_drop: got %b expected 0", o_drop); end
    checks++; if (o_drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop_cnt: got %0d expected 0", o_drop_cnt); end
    checks++; if ({o_data, o_flags} !== 36'h0) begin errors++; $display("FAIL reset_head: got %h/%b expected 0/0000", o_data, o_flags); end
  endtask

  task automatic test_single();
    i_res = 32'h3FA00000; i_ovf = 1'b0; i_res_vld = 1'b1; i_rdy = 1'b1;
    tick();
    i_res_vld = 1'b0;
    checks++; if (o_vld !== 1'b1) begin errors++; $display("FAIL single_vld: got %b expected 1", o_vld); end
    checks++; if (o_data !== 32'h3FA00000) begin errors++; $display("FAIL single_data: got %h expected 3fa00000", o_data); end
    checks++; if (o_flags !== 4'b0000) begin errors++; $display("FAIL single_flags: got %b expected 0000", o_flags); end
    checks++; if (o_count !== 4'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", o_count); end
    tick();
    checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL single_empty: got %b expected 1", o_empty); end
    checks++; if (o_vld !== 1'b0) begin errors++; $display("FAIL single_vld_after: got %b expected 0", o_vld); end
    i_rdy = 1'b0;
  endtask

  task automatic test_classify();
    logic [31:0] vals [4];
    logic [3:0]  exp_flags [4];
    vals[0] = 32'h7FC00000; exp_flags[0] = 4'b0100;
    vals[1] = 32'h7F800000; exp_flags[1] = 4'b0010;
    vals[2] = 32'h80000000; exp_flags[2] = 4'b0001;
    vals[3] = 32'h7F7FFFFF; exp_flags[3] = 4'b1000;
    i_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      i_res = vals[i]; i_ovf = (i == 3); i_res_vld = 1'b1;
      tick();
    end
    i_res_vld = 1'b0; i_ovf = 1'b0;
    checks++; if (o_count !== 4'd4) begin errors++; $display("FAIL class_count: got %0d expected 4", o_count); end
    tick();
    checks++; if (o_data !== 32'h7FC00000) begin errors++; $display("FAIL class_hold: got %h expected 7fc00000", o_data); end
    i_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (o_vld !== 1'b1 || o_data !== vals[i] || o_flags !== exp_flags[i]) begin
        errors++; $display("FAIL class_pop%0d: got vld=%b %h/%b expected 1 %h/%b", i, o_vld, o_data, o_flags, vals[i], exp_flags[i]);
      end
      tick();
    end
    checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL class_empty: got %b expected 1", o_empty); end
    checks++; if (o_sticky !== 4'b1111) begin errors++; $display("FAIL class_sticky: got %b expected 1111", o_sticky); end
    i_rdy = 1'b0;
  endtask

  task automatic test_overflow_drop();
    int n;
    i_clr_sticky = 1'b1; tick(); i_clr_sticky = 1'b0;
    i_rdy = 1'b0; i_res = 32'h3F800000;
    for (int i = 0; i < DEPTH + 2; i++) begin
      i_res_vld = 1'b1; tick();
    end
    i_res_vld = 1'b0;
    checks++; if (o_full !== 1'b1) begin errors++; $display("FAIL ovfl_full: got %b expected 1", o_full); end
    checks++; if (o_count !== 4'(DEPTH)) begin errors++; $display("FAIL ovfl_count: got %0d expected %0d", o_count, DEPTH); end
    checks++; if (o_drop !== 1'b1) begin errors++; $display("FAIL ovfl_drop: got %b expected 1", o_drop); end
    checks++; if (o_drop_cnt !== EXP_DROPS) begin errors++; $display("FAIL ovfl_drop_cnt: got %0d expected %0d", o_drop_cnt, EXP_DROPS); end
    checks++; if (o_sticky !== 4'b0000) begin errors++; $display("FAIL ovfl_sticky: got %b expected 0000", o_sticky); end
    i_rdy = 1'b1; n = 0;
    for (int c = 0; c < 3 * DEPTH && o_vld === 1'b1; c++) begin
      checks++; if (o_data !== 32'h3F800000) begin errors++; $display("FAIL ovfl_drain_data: got %h expected 3f800000", o_data); end
      n++; tick();
    end
    checks++; if (n != DEPTH) begin errors++; $display("FAIL ovfl_drain_n: got %0d expected %0d", n, DEPTH); end
    i_rdy = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] expv;
    i_clr_sticky = 1'b1; tick(); i_clr_sticky = 1'b0;
    i_rdy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      i_res = 32'h40000000 | 32'(i); i_res_vld = 1'b1; tick();
    end
    i_res = 32'h7F800000; i_res_vld = 1'b1; i_rdy = 1'b1;
    tick();
    i_res_vld = 1'b0; i_rdy = 1'b0;
    checks++; if (o_count !== 4'(DEPTH) || o_full !== 1'b1) begin errors++; $display("FAIL b2b_count: got %0d full=%b expected %0d full=1", o_count, o_full, DEPTH); end
    checks++; if (o_drop !== 1'b0) begin errors++; $display("FAIL b2b_drop: got %b expected 0", o_drop); end
    checks++; if (o_drop_cnt !== EXP_DROPS) begin errors++; $display("FAIL b2b_drop_cnt: got %0d expected %0d", o_drop_cnt, EXP_DROPS); end
    i_rdy = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      expv = (k == DEPTH - 1) ? 32'h7F800000 : (32'h40000000 | 32'(k + 1));
      checks++; if (o_vld !== 1'b1 || o_data !== expv) begin errors++; $display("FAIL b2b_order%0d: got vld=%b %h expected 1 %h", k, o_vld, o_data, expv); end
      tick();
    end
    checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL b2b_empty: got %b expected 1", o_empty); end
    i_rdy = 1'b0;
  endtask

  task automatic test_clr_with_push();
    i_clr_sticky = 1'b1; i_res = 32'h7FC00001; i_res_vld = 1'b1; i_rdy = 1'b1;
    tick();
    i_clr_sticky = 1'b0; i_res_vld = 1'b0;
    checks++; if (o_sticky !== 4'b0100) begin errors++; $display("FAIL clr_sticky: got %b expected 0100", o_sticky); end
    checks++; if (o_drop !== 1'b0) begin errors++; $display("FAIL clr_drop: got %b expected 0", o_drop); end
    checks++; if (o_flags !== 4'b0100) begin errors++; $display("FAIL clr_head_flags: got %b expected 0100", o_flags); end
    tick();
    i_rdy = 1'b0;
  endtask

  task automatic test_reset_midstream();
    i_rdy = 1'b0; i_ovf = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i_res = 32'h3F800000; i_res_vld = 1'b1; tick();
    end
    checks++; if (o_count !== 4'd3) begin errors++; $display("FAIL mid_pre_count: got %0d expected 3", o_count); end
    rst = 1'b1; i_res_vld = 1'b1;
    tick();
    rst = 1'b0; i_res_vld = 1'b0; i_ovf = 1'b0;
    checks++; if (o_count !== 4'd0) begin errors++; $display("FAIL mid_count: got %0d expected 0", o_count); end
    checks++; if (o_vld !== 1'b0) begin errors++; $display("FAIL mid_vld: got %b expected 0", o_vld); end
    checks++; if (o_sticky !== 4'b0000) begin errors++; $display("FAIL mid_sticky: got %b expected 0000", o_sticky); end
    checks++; if (o_drop_cnt !== 16'd0) begin errors++; $display("FAIL mid_drop_cnt: got %0d expected 0", o_drop_cnt); end
    tick();
    checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL mid_empty: got %b expected 1", o_empty); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_classify();
    test_overflow_drop();
    test_back_to_back();
    test_clr_with_push();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
